seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
- Downstream consumer of the up/down key counter value.
- Converts a binary count to 4 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Latches the result and drives the board's multiplexed 4-digit common-anode 7-segment display on DIG_1..4 / SEG_0..7.
- Replaces the constant tie-offs on those pins in the board top.

Parameters:
- DATA_W, 14, width of binary input value.
- MAX_VAL, 9999, largest displayable value; anything above shows overflow.
- SCAN_DIV, 50000, FPGA_CLK cycles per digit slot (1 ms at 50 MHz).
- BLANK_CYC, 500, cycles at the start of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.

Ports:
- FPGA_CLK  in  1  50 MHz system clock.
- RESET_BUT  in  1  asynchronous active-low reset.
- value_i  in  DATA_W  binary value to display.
- value_vld_i  in  1  one-cycle strobe: sample value_i.
- dp_i  in  4  decimal point per digit, 1 = lit; sampled with value_i.
- busy_o  out  1  conversion in progress.
- dig_n_o  out  4  digit enables, active-low; bit 0 = ones digit.
- seg_n_o  out  8  segments, active-low; bits 0..6 = a..g, bit 7 = dp.

Behaviour:
- Reset (async assert, sync release on FPGA_CLK):
  - dig_n_o=4'hF, seg_n_o=8'hFF, busy_o=0.
  - Display BCD registers = 0, dp registers = 0, overflow flag = 0, pending slot empty, scan index = 0, prescaler = 0.
- Conversion FSM states: IDLE, CHECK, SHIFT, LATCH.
  - IDLE: on value_vld_i (or pending slot full), capture value/dp into the work register, clear pending, go to CHECK.
  - CHECK (1 cycle): if value > MAX_VAL, set ovf and go to LATCH. Else clear the BCD accumulator and go to SHIFT.
  - SHIFT: exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - LATCH (1 cycle): copy BCD, dp and ovf into display registers, go to IDLE.
- Latency: strobe at cycle 0 -> display registers updated at the end of cycle DATA_W+2 (cycle 16 with defaults); visible from the next active scan slot.
- busy_o is high in CHECK, SHIFT and LATCH, and low in IDLE.
- value_vld_i while busy_o=1: stored into a 1-deep pending slot; a later strobe overwrites it (last wins). The pending value is processed immediately after LATCH with no extra idle cycle. Strobes are never lost except by overwrite.
- Strobe in the same cycle as LATCH counts as busy and goes to pending.
- Scan: prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, scan index increments mod 4 (3 -> 0).
  - While prescaler < BLANK_CYC: dig_n_o=4'hF, seg_n_o=8'hFF.
  - Otherwise: dig_n_o = ~(1<<index), seg_n_o = ~{dp[index], glyph(bcd[index])}.
  - Scan runs continuously, independent of the FSM.
  - Outputs are registered: 1-cycle delay from prescaler/index to pins.
- Glyphs:
  - 0-9: standard a..g.
  - ovf=1: every digit shows '-' (g only); dp forced off.
  - Non-decimal nibble (unreachable): blank.
- Reset mid-conversion: all state cleared, pending discarded, display returns to 0000.

Optional Feature:
- SEG7_LZB_EN defined: leading-zero blanking. Digits above the most significant nonzero digit are blanked (seg_n_o=8'hFF, dig still scanned). Ones digit always shows. A blanked digit whose dp bit is 1 still lights dp.
- Not defined: all four digits always show, zeros included.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4.
  - Active-low glyph constants SEG_0..SEG_9, SEG_DASH=8'hBF, SEG_BLANK=8'hFF.
  - Function bcd_to_seg(nibble) returning active-high a..g.
- Sub-module bin2bcd_seq: IDLE/CHECK/SHIFT/LATCH FSM plus the shift-add-3 datapath, with start/busy/done handshake. The top handles pending slot, scan, glyph lookup and output registers.

Test Plan:
- Reset, no strobe -> busy_o=0; in active slots dig_n_o cycles E,D,B,7; seg_n_o=~SEG_0 (8'hC0) each; 8'hFF during BLANK_CYC window. Reduce SCAN_DIV=20, BLANK_CYC=4 in bench.
- value_i=1234, dp_i=4'b0100 strobe -> busy_o high 16 cycles; then digit0=4 (8'h99), digit1=3 (8'hB0), digit2=2 with dp (8'h24), digit3=1 (8'hF9).
- value_i=9999 -> all digits 8'h90. Then value_i=10000 -> busy_o high only 2 cycles (CHECK, LATCH); all digits 8'hBF.
- Strobe 42, then strobe 7 and 88 while busy -> 42 displayed, then 88 (7 dropped by overwrite); busy_o stays high continuously through both conversions.
- Assert RESET_BUT mid-SHIFT of 5555 -> outputs immediately 4'hF/8'hFF; after release display shows 0000 and busy_o=0.
- With SEG7_LZB_EN: value 7 -> digits 3..1 seg_n_o=8'hFF, digit0=8'hF8; value 0 -> only digit0 shows 8'hC0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display.
// Glyph table, digit count and the conversion FSM state type.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns, bit 7 = dp (off), bits 6..0 = g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_LATCH
    } conv_state_t;

    // Active-high a..g for one BCD nibble; non-decimal codes are blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [7:0] s;
        s = SEG_BLANK;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return ~s[6:0];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Ports: clk, rst_n, start/bin_in/dp_in in; busy, done, bcd, dp, ovf out.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin_in,
    input  logic [3:0]              dp_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [3:0]              dp,
    output logic                    ovf
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [31:0] MAX_U = 32'(MAX_VAL);

    conv_state_t             state;
    logic [DATA_W-1:0]       work;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            work  <= '0;
            cnt   <= '0;
            bcd   <= '0;
            dp    <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work  <= bin_in;
                        dp    <= dp_in;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (32'(work) > MAX_U) begin
                        ovf   <= 1'b1;
                        state <= ST_LATCH;
                    end else begin
                        ovf   <= 1'b0;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, work} <= {adj[4*NUM_DIGITS-2:0], work, 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1))
                        state <= ST_LATCH;
                end
                ST_LATCH: begin
                    // Back-to-back restart keeps busy high across jobs.
                    if (start) begin
                        work  <= bin_in;
                        dp    <= dp_in;
                        state <= ST_CHECK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Binary value to multiplexed 4-digit common-anode 7-segment display.
// Ports: FPGA_CLK, RESET_BUT, value_i, value_vld_i, dp_i in; busy_o, dig_n_o, seg_n_o out.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int MAX_VAL   = 9999,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic              FPGA_CLK,
    input  logic              RESET_BUT,
    input  logic [DATA_W-1:0] value_i,
    input  logic              value_vld_i,
    input  logic [3:0]        dp_i,
    output logic              busy_o,
    output logic [3:0]        dig_n_o,
    output logic [7:0]        seg_n_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                    pend_full;
    logic [DATA_W-1:0]       pend_val;
    logic [3:0]              pend_dp;
    logic                    start;
    logic                    accept;
    logic                    done;
    logic [DATA_W-1:0]       start_val;
    logic [3:0]              start_dp;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic [3:0]              conv_dp;
    logic                    conv_ovf;

    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [3:0]              disp_dp;
    logic                    disp_ovf;
    logic [PW-1:0]           presc;
    logic [1:0]              idx;
    logic                    blank_win;
    logic [7:0]              seg_next;

    // A fresh strobe always wins over the pending slot.
    assign start     = value_vld_i | pend_full;
    assign start_val = value_vld_i ? value_i : pend_val;
    assign start_dp  = value_vld_i ? dp_i : pend_dp;
    assign accept    = start & (~busy_o | done);

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .MAX_VAL (MAX_VAL)
    ) u_conv (
        .clk    (FPGA_CLK),
        .rst_n  (RESET_BUT),
        .start  (start),
        .bin_in (start_val),
        .dp_in  (start_dp),
        .busy   (busy_o),
        .done   (done),
        .bcd    (conv_bcd),
        .dp     (conv_dp),
        .ovf    (conv_ovf)
    );

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            pend_full <= 1'b0;
            pend_val  <= '0;
            pend_dp   <= '0;
            disp_bcd  <= '0;
            disp_dp   <= '0;
            disp_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                pend_full <= 1'b0;
            end else if (value_vld_i) begin
                pend_full <= 1'b1;
                pend_val  <= value_i;
                pend_dp   <= dp_i;
            end
            if (done) begin
                disp_bcd <= conv_bcd;
                disp_dp  <= conv_dp;
                disp_ovf <= conv_ovf;
            end
        end
    end

    assign blank_win = 32'(presc) < 32'(BLANK_CYC);

    always_comb begin
        seg_next = {~disp_dp[idx], ~bcd_to_seg(disp_bcd[{idx, 2'b00} +: 4])};
        if (disp_ovf)
            seg_next = SEG_DASH;
`ifdef SEG7_LZB_EN
        else begin
            case (idx)
                2'd1: if (disp_bcd[15:4] == '0) seg_next = {~disp_dp[idx], 7'h7F};
                2'd2: if (disp_bcd[15:8] == '0) seg_next = {~disp_dp[idx], 7'h7F};
                2'd3: if (disp_bcd[15:12] == '0) seg_next = {~disp_dp[idx], 7'h7F};
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            presc   <= '0;
            idx     <= '0;
            dig_n_o <= 4'hF;
            seg_n_o <= SEG_BLANK;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            dig_n_o <= blank_win ? 4'hF : ~(4'b0001 << idx);
            seg_n_o <= blank_win ? SEG_BLANK : seg_next;
        end
    end

endmodule
